spi_slave_ctrl: RTL and testbench
=================================

# spi_slave_ctrl

Serial front-end that drives the single-port RAM in the SPI subsystem. It deserialises 10-bit MOSI frames into `rx_data[9:0]` with a one-cycle `rx_valid` strobe. It tracks the read-address / read-data pairing, and serialises the RAM's `tx_data[7:0]` back onto MISO when the RAM asserts `tx_valid`. It is the initiator side of the RAM's `din`/`rx_valid`/`dout`/`tx_valid` interface.

## Interface
- `FRAME_W`, 10: bits per MOSI frame. Bits [9:8] are the command, bits [7:0] are the address or data.
- `DATA_W`, 8: width of read data returned on MISO.
- `clk` input 1: system clock. All sampling is on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `ss_n` input 1: slave select, active low, synchronous to `clk`.
- `mosi` input 1: serial data in, MSB first.
- `miso` output 1: serial data out, MSB first.
- `rx_data` output FRAME_W: assembled frame to the RAM `din`.
- `rx_valid` output 1: one-cycle strobe; `rx_data` is valid.
- `tx_data` input DATA_W: read data from the RAM `dout`.
- `tx_valid` input 1: RAM read data valid.

## Operation
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE: when `ss_n`=0, go to CHK_CMD; otherwise stay.
- CHK_CMD:
  - Sample `mosi` as frame bit 9.
  - If bit 9 is 0, go to WRITE.
  - If bit 9 is 1 and `rd_addr_seen`=0, go to READ_ADD.
  - If bit 9 is 1 and `rd_addr_seen`=1, go to READ_DATA.
- WRITE, READ_ADD, READ_DATA: shift in bits 8..0 (9 cycles) into a shift register, MSB first.
- Frame complete (10th bit captured):
  - Register `rx_data` and pulse `rx_valid` for exactly one cycle.
  - Bits [9:8] are forwarded unchanged; the command is not validated.
- `rd_addr_seen` (internal flag):
  - Set on completion of a READ_ADD frame.
  - Cleared on completion of a READ_DATA frame.
  - Unchanged by WRITE frames and by aborted frames.
- READ_DATA, after `rx_valid`:
  - Wait for `tx_valid`=1 and latch `tx_data` into the output shift register.
  - Drive `miso` = bit 7 in the next cycle, then bits 6..0 on successive cycles (8 cycles total).
  - Then `miso`=0, and remain in READ_DATA until `ss_n`=1.
- `tx_valid` outside the READ_DATA wait window is ignored (no latch, no MISO activity).
- WRITE and READ_ADD: after `rx_valid`, stay in the state with no further shifting until `ss_n`=1.
- `ss_n`=1 in any non-IDLE state:
  - Go to IDLE next cycle and clear the bit counter.
  - A partial frame produces no `rx_valid`.
  - MISO shifting aborts and `miso`=0.
- Bit counter: 4 bits. Counts captured bits 0..9 and serialised bits 0..7; it saturates and never wraps into a second frame within one `ss_n` low period.

## Timing
- Reset values: `miso`=0, `rx_data`=0, `rx_valid`=0, state IDLE, `rd_addr_seen`=0, counter 0.
- Reset is asynchronous and takes effect mid-frame; no `rx_valid` is emitted afterwards for that frame.
- Reference cycle C0 is the first edge that sees `ss_n`=0 in IDLE.
  - C1: CHK_CMD samples bit 9.
  - C2..C10: bits 8..0 sampled.
  - C11: `rx_valid`=1, `rx_data` holds the frame.
  - C12: `rx_valid`=0; `rx_data` holds its value until the next frame completes.
- MOSI-to-`rx_valid` latency: 10 cycles from the bit-9 sample edge.
- Read return: if `tx_valid` is first seen at edge Ct, `miso` carries bit 7 during Ct+1 .. Ct+1+7 carries bit 0; `miso`=0 from Ct+9.
- `tx_valid` coincident with `ss_n` rising: the abort wins; no latch.
- Only one `tx_valid` latch per READ_DATA frame; later pulses are ignored.
- Back-to-back frames require `ss_n`=1 for at least one edge between them.

## Test plan
- Write pair:
  - Stimulus: frames 00_0000_0101, then 01_1010_1010, each with `ss_n` high between.
  - Required: `rx_valid` pulses at C11 of each frame with `rx_data`=0x005, then 0x1AA; `miso` stays 0.
- Read pair:
  - Stimulus: frame 10_0000_0101, then 11_xxxx_xxxx; the model returns `tx_valid` with `tx_data`=0xC3 one cycle after the second `rx_valid`.
  - Required: `miso` serialises 1,1,0,0,0,0,1,1, then 0; `rd_addr_seen` is 1 after frame 1 and 0 after frame 2.
- Abort:
  - Stimulus: raise `ss_n` after 6 bits of a WRITE frame.
  - Required: no `rx_valid`; state returns to IDLE; a following full frame is captured correctly.
- Reset mid-read:
  - Stimulus: assert `rst` during the 4th MISO bit.
  - Required: `miso`, `rx_valid` and `rx_data` go to 0 immediately (asynchronous); `rd_addr_seen`=0, so the next 1x frame routes to READ_ADD.
- Stray `tx_valid`:
  - Stimulus: pulse `tx_valid` during a WRITE frame and in IDLE.
  - Required: `miso` remains 0 and no state change occurs.
- Repeated read-address:
  - Stimulus: two consecutive 10_ frames.
  - Required: the second frame is routed to READ_DATA, `rx_valid` is still emitted with bits [9:8]=10 unchanged, and `rd_addr_seen` clears.

Source files
------------

// File: rtl/spi_slave_ctrl.sv
// SPI slave front-end for the single-port RAM: deserialises 10-bit MOSI frames
// into rx_data/rx_valid and serialises RAM read data back out on MISO.
module spi_slave_ctrl #(
  parameter int FRAME_W = 10,
  parameter int DATA_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ss_n,
  input  logic               mosi,
  output logic               miso,
  output logic [FRAME_W-1:0] rx_data,
  output logic               rx_valid,
  input  logic [DATA_W-1:0]  tx_data,
  input  logic               tx_valid
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_t;

  localparam logic [3:0] CNT_FRAME = 4'(FRAME_W);
  localparam logic [3:0] CNT_DATA  = 4'(DATA_W);

  state_t             state;
  state_t             next_state;
  logic [FRAME_W-1:0] shift_reg;
  logic [DATA_W-1:0]  tx_shift;
  logic [3:0]         cnt;
  logic               frame_done;
  logic               tx_busy;
  logic               rd_addr_seen;
  logic               frame_full;

  assign frame_full = (cnt == CNT_FRAME);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (!ss_n) next_state = CHK_CMD;
      end
      CHK_CMD: begin
        if (ss_n)              next_state = IDLE;
        else if (!mosi)        next_state = WRITE;
        else if (rd_addr_seen) next_state = READ_DATA;
        else                   next_state = READ_ADD;
      end
      WRITE, READ_ADD, READ_DATA: begin
        if (ss_n) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // One counter serves both directions: captured frame bits, then (after a
  // tx_data latch) serialised MISO bits. It stops at its limit instead of
  // wrapping, so a long ss_n-low period never starts a second frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg    <= '0;
      tx_shift     <= '0;
      cnt          <= 4'd0;
      frame_done   <= 1'b0;
      tx_busy      <= 1'b0;
      rd_addr_seen <= 1'b0;
      miso         <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (ss_n) begin
        // Abort (or idle): drop any partial frame and any MISO transfer.
        cnt        <= 4'd0;
        frame_done <= 1'b0;
        tx_busy    <= 1'b0;
        miso       <= 1'b0;
      end else begin
        case (state)
          CHK_CMD: begin
            shift_reg <= {shift_reg[FRAME_W-2:0], mosi};
            cnt       <= 4'd1;
          end
          WRITE, READ_ADD, READ_DATA: begin
            if (!frame_done) begin
              if (!frame_full) begin
                shift_reg <= {shift_reg[FRAME_W-2:0], mosi};
                cnt       <= cnt + 4'd1;
              end else begin
                rx_data    <= shift_reg;
                rx_valid   <= 1'b1;
                frame_done <= 1'b1;
                if (state == READ_ADD)       rd_addr_seen <= 1'b1;
                else if (state == READ_DATA) rd_addr_seen <= 1'b0;
              end
            end else if (state == READ_DATA) begin
              if (!tx_busy) begin
                if (tx_valid) begin
                  tx_shift <= tx_data;
                  tx_busy  <= 1'b1;
                  cnt      <= 4'd0;
                end
              end else if (cnt < CNT_DATA) begin
                miso     <= tx_shift[DATA_W-1];
                tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
                cnt      <= cnt + 4'd1;
              end else begin
                miso <= 1'b0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Directed bench for spi_slave_ctrl: frames driven on negedges, results
// sampled on negedges, rx_data checked against a scoreboard queue.
module tb_spi_slave_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       ss_n;
  logic       mosi;
  logic       miso;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;

  int checks   = 0;
  int failures = 0;
  int rv_count = 0;
  int exp_rv   = 0;
  logic [9:0] sb[$];
  logic [2:0] st;

  localparam logic [2:0] S_IDLE = 3'd0, S_WRITE = 3'd2, S_READ_ADD = 3'd3, S_READ_DATA = 3'd4;

  spi_slave_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .ss_n     (ss_n),
    .mosi     (mosi),
    .miso     (miso),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  always #5 clk = ~clk;
  assign st = dut.state;

  always @(negedge clk) if (rx_valid === 1'b1) rv_count++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives a full frame from IDLE and checks the rx_valid strobe at C11.
  task automatic send_frame(input logic [9:0] f, input logic stray);
    logic [9:0] exp;
    sb.push_back(f);
    exp_rv++;
    @(negedge clk);
    ss_n = 1'b0;
    tx_valid = stray;
    for (int i = 9; i >= 0; i--) begin
      @(negedge clk);
      mosi = f[i];
    end
    @(negedge clk);
    chk("rx_valid_pre", {31'd0, rx_valid}, 32'd0);
    @(negedge clk);
    chk("rx_valid", {31'd0, rx_valid}, 32'd1);
    exp = (sb.size() > 0) ? sb.pop_front() : 10'h3FF;
    chk("rx_data", {22'd0, rx_data}, {22'd0, exp});
    chk("miso_quiet", {31'd0, miso}, 32'd0);
    tx_valid = 1'b0;
  endtask

  task automatic tx_return(input logic [7:0] d, input int nchk);
    tx_valid = 1'b1;
    tx_data  = d;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    chk("rx_valid_post", {31'd0, rx_valid}, 32'd0);
    chk("miso_latch", {31'd0, miso}, 32'd0);
    for (int k = 1; k <= nchk; k++) begin
      @(negedge clk);
      chk($sformatf("miso_bit%0d", 8 - k), {31'd0, miso}, {31'd0, d[8-k]});
    end
  endtask

  task automatic end_frame();
    @(negedge clk);
    chk("rx_valid_end", {31'd0, rx_valid}, 32'd0);
    ss_n = 1'b1;
    @(negedge clk);
    chk("state_idle", {29'd0, st}, {29'd0, S_IDLE});
    chk("miso_idle", {31'd0, miso}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ss_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    @(negedge clk);
    chk("rst_miso", {31'd0, miso}, 32'd0);
    chk("rst_rx_data", {22'd0, rx_data}, 32'd0);
    chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_state", {29'd0, st}, {29'd0, S_IDLE});
    chk("rst_seen", {31'd0, dut.rd_addr_seen}, 32'd0);
    chk("rst_cnt", {28'd0, dut.cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Write pair
    send_frame(10'b00_0000_0101, 1'b0);
    end_frame();
    send_frame(10'b01_1010_1010, 1'b0);
    end_frame();

    // Read pair with 0xC3 returned
    send_frame(10'b10_0000_0101, 1'b0);
    chk("rd1_state", {29'd0, st}, {29'd0, S_READ_ADD});
    chk("rd1_seen", {31'd0, dut.rd_addr_seen}, 32'd1);
    end_frame();
    send_frame(10'b11_0101_0011, 1'b0);
    chk("rd2_state", {29'd0, st}, {29'd0, S_READ_DATA});
    chk("rd2_seen", {31'd0, dut.rd_addr_seen}, 32'd0);
    tx_return(8'hC3, 8);
    @(negedge clk);
    chk("miso_tail", {31'd0, miso}, 32'd0);
    tx_valid = 1'b1; tx_data = 8'hFF;
    @(negedge clk);
    tx_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("miso_relatch", {31'd0, miso}, 32'd0);
    end
    end_frame();

    // Abort after 6 bits, then a full frame
    @(negedge clk);
    ss_n = 1'b0;
    for (int i = 9; i >= 4; i--) begin
      @(negedge clk);
      mosi = 1'(10'b00_1111_0000 >> i);
    end
    @(negedge clk);
    ss_n = 1'b1;
    @(negedge clk);
    chk("abort_state", {29'd0, st}, {29'd0, S_IDLE});
    chk("abort_cnt", {28'd0, dut.cnt}, 32'd0);
    repeat (12) @(negedge clk);
    chk("abort_no_rv", rv_count, exp_rv);
    send_frame(10'b00_1111_0000, 1'b0);
    end_frame();

    // Stray tx_valid during WRITE and in IDLE
    send_frame(10'b00_0011_0011, 1'b1);
    chk("stray_state", {29'd0, st}, {29'd0, S_WRITE});
    tx_valid = 1'b1; tx_data = 8'hFF;
    repeat (3) @(negedge clk);
    chk("stray_miso_wr", {31'd0, miso}, 32'd0);
    tx_valid = 1'b0;
    end_frame();
    tx_valid = 1'b1;
    repeat (4) @(negedge clk);
    chk("stray_idle_state", {29'd0, st}, {29'd0, S_IDLE});
    chk("stray_idle_miso", {31'd0, miso}, 32'd0);
    tx_valid = 1'b0;

    // Repeated read-address
    send_frame(10'b10_0001_0001, 1'b0);
    chk("rep1_seen", {31'd0, dut.rd_addr_seen}, 32'd1);
    end_frame();
    send_frame(10'b10_1110_1110, 1'b0);
    chk("rep2_state", {29'd0, st}, {29'd0, S_READ_DATA});
    chk("rep2_cmd", {30'd0, rx_data[9:8]}, 32'd2);
    chk("rep2_seen", {31'd0, dut.rd_addr_seen}, 32'd0);
    end_frame();

    // Reset during the 4th MISO bit of a read
    send_frame(10'b10_1010_1010, 1'b0);
    chk("rr1_state", {29'd0, st}, {29'd0, S_READ_ADD});
    end_frame();
    send_frame(10'b11_1100_1100, 1'b0);
    tx_return(8'hB8, 4);
    #2 rst = 1'b1;
    #1;
    chk("arst_miso", {31'd0, miso}, 32'd0);
    chk("arst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("arst_rx_data", {22'd0, rx_data}, 32'd0);
    chk("arst_seen", {31'd0, dut.rd_addr_seen}, 32'd0);
    chk("arst_state", {29'd0, st}, {29'd0, S_IDLE});
    ss_n = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send_frame(10'b11_0000_0001, 1'b0);
    chk("post_rst_state", {29'd0, st}, {29'd0, S_READ_ADD});
    chk("post_rst_seen", {31'd0, dut.rd_addr_seen}, 32'd1);
    end_frame();

    repeat (2) @(negedge clk);
    chk("rv_total", rv_count, exp_rv);
    chk("sb_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
